riscv_hwloop_cfg_sched: RTL and testbench

// - Owns the hardware-loop register sets (start, end, counter) that feed the hwloop controller comparators.
// - Serves two requesters, ID stage (lp.* instructions) and CSR unit (csrr/csrw, debug/context restore), over one write port.
// - Sequences multi-beat lp.setup; applies controller decrement requests.

---
 rtl/riscv_hwloop_cfg_sched_if.sv | 52 +++++
 rtl/riscv_hwloop_cfg_sched.sv | 156 +++++++++++++++
 tb/tb_riscv_hwloop_cfg_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_hwloop_cfg_sched_if.sv
// Request/response bundle between the ID stage, the CSR unit, the hwloop
// controller and the hardware-loop register scheduler.
interface riscv_hwloop_cfg_sched_if #(
   parameter int N_REGS = 2
);
   localparam int IW = $clog2(N_REGS);

   logic                     id_req_i;
   logic [1:0]               id_op_i;
   logic [IW-1:0]            id_idx_i;
   logic [31:0]              id_start_i;
   logic [31:0]              id_end_i;
   logic [31:0]              id_cnt_i;
   logic                     id_gnt_o;
   logic                     id_err_o;
   logic                     csr_req_i;
   logic                     csr_we_i;
   logic [IW-1:0]            csr_idx_i;
   logic [1:0]               csr_field_i;
   logic [31:0]              csr_wdata_i;
   logic                     csr_gnt_o;
   logic [31:0]              csr_rdata_o;
   logic [N_REGS-1:0]        hwlp_dec_cnt_i;
   logic [N_REGS-1:0][31:0]  hwlp_start_addr_o;
   logic [N_REGS-1:0][31:0]  hwlp_end_addr_o;
   logic [N_REGS-1:0][31:0]  hwlp_counter_o;
   logic                     busy_o;

   modport slave (
      input  id_req_i, id_op_i, id_idx_i,
      input  id_start_i, id_end_i, id_cnt_i,
      output id_gnt_o, id_err_o,
      input  csr_req_i, csr_we_i, csr_idx_i,
      input  csr_field_i, csr_wdata_i,
      output csr_gnt_o, csr_rdata_o,
      input  hwlp_dec_cnt_i,
      output hwlp_start_addr_o, hwlp_end_addr_o,
      output hwlp_counter_o, busy_o
   );

   modport master (
      output id_req_i, id_op_i, id_idx_i,
      output id_start_i, id_end_i, id_cnt_i,
      input  id_gnt_o, id_err_o,
      output csr_req_i, csr_we_i, csr_idx_i,
      output csr_field_i, csr_wdata_i,
      input  csr_gnt_o, csr_rdata_o,
      output hwlp_dec_cnt_i,
      input  hwlp_start_addr_o, hwlp_end_addr_o,
      input  hwlp_counter_o, busy_o
   );
endinterface

// File: rtl/riscv_hwloop_cfg_sched.sv
// Hardware-loop register sets shared by ID and CSR over one write port.
// Optional HWLP_ADDR_CHECK_EN rejects malformed SETUP/END address pairs.
module riscv_hwloop_cfg_sched #(
   parameter int N_REGS     = 2,
   parameter int STARVE_MAX = 4
) (
   input logic clk,
   input logic rst,
   riscv_hwloop_cfg_sched_if.slave bus
);
   localparam int IW = $clog2(N_REGS);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_END   = 2'b01;
   localparam logic [1:0] OP_COUNT = 2'b10;
   localparam logic [1:0] OP_SETUP = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SU_END = 2'b01,
      SU_CNT = 2'b10
   } state_e;

   state_e                   state_q;
   logic [IW-1:0]            su_idx_q;
   logic [31:0]              su_end_q;
   logic [31:0]              su_cnt_q;
   logic [3:0]               starve_q;
   logic [31:0]              rdata_q;

   logic [N_REGS-1:0][31:0]  start_q, start_d;
   logic [N_REGS-1:0][31:0]  end_q, end_d;
   logic [N_REGS-1:0][31:0]  cnt_q, cnt_d;

   logic idle;
   logic csr_prio;
   logic id_gnt;
   logic csr_gnt;
   logic addr_bad;
   logic id_wr;
   logic csr_wr;

   assign idle     = (state_q == IDLE);
   assign csr_prio = bus.csr_req_i && (starve_q == SMAX);
   assign id_gnt   = idle && bus.id_req_i && !csr_prio;
   assign csr_gnt  = idle && bus.csr_req_i && !id_gnt;

`ifdef HWLP_ADDR_CHECK_EN
   // END alone is checked against the start already held for that set
   logic [31:0] chk_start;
   logic        chk_op;
   assign chk_start = (bus.id_op_i == OP_SETUP) ?
                      bus.id_start_i : start_q[bus.id_idx_i];
   assign chk_op    = (bus.id_op_i == OP_SETUP) ||
                      (bus.id_op_i == OP_END);
   assign addr_bad  = chk_op &&
                      ((bus.id_end_i <= chk_start) ||
                       bus.id_end_i[0] || chk_start[0]);
`else
   assign addr_bad = 1'b0;
`endif

   assign id_wr  = id_gnt && !addr_bad;
   assign csr_wr = csr_gnt && bus.csr_we_i;

   always_comb begin
      start_d = start_q;
      end_d   = end_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < N_REGS; i++) begin
         if (bus.hwlp_dec_cnt_i[i] && (cnt_q[i] != 32'd0))
            cnt_d[i] = cnt_q[i] - 32'd1;
      end
      // writes come after decrements so a same-edge write wins
      if (id_wr) begin
         unique case (bus.id_op_i)
            OP_START: start_d[bus.id_idx_i] = bus.id_start_i;
            OP_END:   end_d[bus.id_idx_i]   = bus.id_end_i;
            OP_COUNT: cnt_d[bus.id_idx_i]   = bus.id_cnt_i;
            OP_SETUP: start_d[bus.id_idx_i] = bus.id_start_i;
            default: ;
         endcase
      end
      if (state_q == SU_END)
         end_d[su_idx_q] = su_end_q;
      if (state_q == SU_CNT)
         cnt_d[su_idx_q] = su_cnt_q;
      if (csr_wr) begin
         unique case (bus.csr_field_i)
            2'b00: start_d[bus.csr_idx_i] = bus.csr_wdata_i;
            2'b01: end_d[bus.csr_idx_i]   = bus.csr_wdata_i;
            2'b10: cnt_d[bus.csr_idx_i]   = bus.csr_wdata_i;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         su_idx_q <= '0;
         su_end_q <= '0;
         su_cnt_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (id_wr && (bus.id_op_i == OP_SETUP)) begin
                  state_q  <= SU_END;
                  su_idx_q <= bus.id_idx_i;
                  su_end_q <= bus.id_end_i;
                  su_cnt_q <= bus.id_cnt_i;
               end
            end
            SU_END:  state_q <= SU_CNT;
            SU_CNT:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_q  <= '0;
         end_q    <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         rdata_q  <= '0;
      end else begin
         start_q <= start_d;
         end_q   <= end_d;
         cnt_q   <= cnt_d;
         if (csr_gnt)
            starve_q <= '0;
         else if (bus.csr_req_i && (starve_q != SMAX))
            starve_q <= starve_q + 4'd1;
         if (csr_gnt && !bus.csr_we_i) begin
            unique case (bus.csr_field_i)
               2'b00:   rdata_q <= start_q[bus.csr_idx_i];
               2'b01:   rdata_q <= end_q[bus.csr_idx_i];
               2'b10:   rdata_q <= cnt_q[bus.csr_idx_i];
               default: rdata_q <= '0;
            endcase
         end
      end
   end

   assign bus.id_gnt_o          = id_gnt;
   assign bus.id_err_o          = id_gnt && addr_bad;
   assign bus.csr_gnt_o         = csr_gnt;
   assign bus.csr_rdata_o       = rdata_q;
   assign bus.hwlp_start_addr_o = start_q;
   assign bus.hwlp_end_addr_o   = end_q;
   assign bus.hwlp_counter_o    = cnt_q;
   assign bus.busy_o            = !idle;
endmodule

// File: tb/tb_riscv_hwloop_cfg_sched.sv
// Directed bench for riscv_hwloop_cfg_sched (default STARVE_MAX=4).
// Expectations follow HWLP_ADDR_CHECK_EN when it is defined.
module tb_riscv_hwloop_cfg_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   riscv_hwloop_cfg_sched_if #(.N_REGS(2)) bus ();

   riscv_hwloop_cfg_sched #(
      .N_REGS(2),
      .STARVE_MAX(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_req_i       = 1'b0;
      bus.id_op_i        = 2'b00;
      bus.id_idx_i       = 1'b0;
      bus.id_start_i     = 32'd0;
      bus.id_end_i       = 32'd0;
      bus.id_cnt_i       = 32'd0;
      bus.csr_req_i      = 1'b0;
      bus.csr_we_i       = 1'b0;
      bus.csr_idx_i      = 1'b0;
      bus.csr_field_i    = 2'b00;
      bus.csr_wdata_i    = 32'd0;
      bus.hwlp_dec_cnt_i = 2'b00;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.hwlp_start_addr_o !== '0 ||
          bus.hwlp_end_addr_o !== '0 ||
          bus.hwlp_counter_o !== '0) begin
         failures++;
         $display("FAIL reset_regs start=%h end=%h cnt=%h want 0",
                  bus.hwlp_start_addr_o, bus.hwlp_end_addr_o,
                  bus.hwlp_counter_o);
      end
      checks++;
      if (bus.busy_o !== 1'b0 || bus.id_gnt_o !== 1'b0 ||
          bus.csr_gnt_o !== 1'b0 || bus.id_err_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl busy=%b idg=%b csg=%b err=%b want 0",
                  bus.busy_o, bus.id_gnt_o, bus.csr_gnt_o, bus.id_err_o);
      end
      checks++;
      if (bus.csr_rdata_o !== 32'd0) begin
         failures++;
         $display("FAIL reset_rdata got=%h want 0", bus.csr_rdata_o);
      end
   endtask

   task automatic test_setup();
      bus.id_req_i   = 1'b1;
      bus.id_op_i    = 2'b11;
      bus.id_idx_i   = 1'b0;
      bus.id_start_i = 32'h100;
      bus.id_end_i   = 32'h120;
      bus.id_cnt_i   = 32'd3;
      #1;
      checks++;
      if (bus.id_gnt_o !== 1'b1 || bus.busy_o !== 1'b0 ||
          bus.id_err_o !== 1'b0) begin
         failures++;
         $display("FAIL setup_gnt gnt=%b busy=%b err=%b want 1 0 0",
                  bus.id_gnt_o, bus.busy_o, bus.id_err_o);
      end
      tick();
      checks++;
      if (bus.id_gnt_o !== 1'b0 || bus.busy_o !== 1'b1 ||
          bus.hwlp_start_addr_o[0] !== 32'h100 ||
          bus.hwlp_end_addr_o[0] !== 32'd0) begin
         failures++;
         $display("FAIL setup_su_end gnt=%b busy=%b st=%h en=%h",
                  bus.id_gnt_o, bus.busy_o,
                  bus.hwlp_start_addr_o[0], bus.hwlp_end_addr_o[0]);
      end
      tick();
      checks++;
      if (bus.id_gnt_o !== 1'b0 || bus.busy_o !== 1'b1 ||
          bus.hwlp_end_addr_o[0] !== 32'h120 ||
          bus.hwlp_counter_o[0] !== 32'd0) begin
         failures++;
         $display("FAIL setup_su_cnt gnt=%b busy=%b en=%h cnt=%h",
                  bus.id_gnt_o, bus.busy_o,
                  bus.hwlp_end_addr_o[0], bus.hwlp_counter_o[0]);
      end
      bus.id_req_i = 1'b0;
      tick();
      checks++;
      if (bus.busy_o !== 1'b0 || bus.hwlp_counter_o[0] !== 32'd3) begin
         failures++;
         $display("FAIL setup_done busy=%b cnt=%h want 0 3",
                  bus.busy_o, bus.hwlp_counter_o[0]);
      end
   endtask

   task automatic test_decrement();
      logic [31:0] exp [3];
      exp[0] = 32'd1;
      exp[1] = 32'd0;
      exp[2] = 32'd0;
      bus.id_req_i = 1'b1;
      bus.id_op_i  = 2'b10;
      bus.id_idx_i = 1'b0;
      bus.id_cnt_i = 32'd2;
      tick();
      bus.id_req_i = 1'b0;
      checks++;
      if (bus.hwlp_counter_o[0] !== 32'd2) begin
         failures++;
         $display("FAIL dec_load got=%h want 2", bus.hwlp_counter_o[0]);
      end
      bus.hwlp_dec_cnt_i = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.hwlp_counter_o[0] !== exp[i]) begin
            failures++;
            $display("FAIL dec_step%0d got=%h want %h",
                     i, bus.hwlp_counter_o[0], exp[i]);
         end
      end
      bus.hwlp_dec_cnt_i = 2'b00;
   endtask

   task automatic test_write_vs_dec();
      bus.id_req_i       = 1'b1;
      bus.id_op_i        = 2'b10;
      bus.id_idx_i       = 1'b1;
      bus.id_cnt_i       = 32'd5;
      bus.hwlp_dec_cnt_i = 2'b10;
      tick();
      bus.id_req_i = 1'b0;
      checks++;
      if (bus.hwlp_counter_o[1] !== 32'd5) begin
         failures++;
         $display("FAIL wr_beats_dec got=%h want 5",
                  bus.hwlp_counter_o[1]);
      end
      tick();
      bus.hwlp_dec_cnt_i = 2'b00;
      checks++;
      if (bus.hwlp_counter_o[1] !== 32'd4) begin
         failures++;
         $display("FAIL dec_set1 got=%h want 4", bus.hwlp_counter_o[1]);
      end
   endtask

   task automatic test_csr();
      bus.csr_req_i   = 1'b1;
      bus.csr_we_i    = 1'b1;
      bus.csr_idx_i   = 1'b1;
      bus.csr_field_i = 2'b00;
      bus.csr_wdata_i = 32'hABCD_0000;
      #1;
      checks++;
      if (bus.csr_gnt_o !== 1'b1 || bus.id_gnt_o !== 1'b0) begin
         failures++;
         $display("FAIL csr_gnt csg=%b idg=%b want 1 0",
                  bus.csr_gnt_o, bus.id_gnt_o);
      end
      tick();
      checks++;
      if (bus.hwlp_start_addr_o[1] !== 32'hABCD_0000) begin
         failures++;
         $display("FAIL csr_wr got=%h want abcd0000",
                  bus.hwlp_start_addr_o[1]);
      end
      bus.csr_field_i = 2'b11;
      bus.csr_wdata_i = 32'hFFFF_FFFF;
      tick();
      checks++;
      if (bus.hwlp_start_addr_o[1] !== 32'hABCD_0000 ||
          bus.hwlp_end_addr_o[1] !== 32'd0 ||
          bus.hwlp_counter_o[1] !== 32'd4) begin
         failures++;
         $display("FAIL csr_wr_rsvd st=%h en=%h cnt=%h",
                  bus.hwlp_start_addr_o[1], bus.hwlp_end_addr_o[1],
                  bus.hwlp_counter_o[1]);
      end
      bus.csr_we_i    = 1'b0;
      bus.csr_idx_i   = 1'b0;
      bus.csr_field_i = 2'b01;
      tick();
      checks++;
      if (bus.csr_rdata_o !== 32'h120) begin
         failures++;
         $display("FAIL csr_rd_end got=%h want 120", bus.csr_rdata_o);
      end
      bus.csr_idx_i      = 1'b1;
      bus.csr_field_i    = 2'b10;
      bus.hwlp_dec_cnt_i = 2'b10;
      tick();
      bus.hwlp_dec_cnt_i = 2'b00;
      checks++;
      if (bus.csr_rdata_o !== 32'd4 ||
          bus.hwlp_counter_o[1] !== 32'd3) begin
         failures++;
         $display("FAIL csr_rd_pre_dec rd=%h cnt=%h want 4 3",
                  bus.csr_rdata_o, bus.hwlp_counter_o[1]);
      end
      bus.csr_field_i = 2'b11;
      tick();
      bus.csr_req_i = 1'b0;
      checks++;
      if (bus.csr_rdata_o !== 32'd0) begin
         failures++;
         $display("FAIL csr_rd_rsvd got=%h want 0", bus.csr_rdata_o);
      end
   endtask

   task automatic test_starve();
      bus.id_req_i    = 1'b1;
      bus.id_op_i     = 2'b00;
      bus.id_idx_i    = 1'b1;
      bus.id_start_i  = 32'h40;
      bus.csr_req_i   = 1'b1;
      bus.csr_we_i    = 1'b0;
      bus.csr_idx_i   = 1'b1;
      bus.csr_field_i = 2'b10;
      #1;
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if (bus.id_gnt_o !== (c != 5) || bus.csr_gnt_o !== (c == 5)) begin
            failures++;
            $display("FAIL starve_cyc%0d idg=%b csg=%b want %b %b",
                     c, bus.id_gnt_o, bus.csr_gnt_o, c != 5, c == 5);
         end
         tick();
         if (c == 5) begin
            checks++;
            if (bus.csr_rdata_o !== 32'd3) begin
               failures++;
               $display("FAIL starve_rdata got=%h want 3",
                        bus.csr_rdata_o);
            end
         end
      end
      clear_inputs();
      checks++;
      if (bus.hwlp_start_addr_o[1] !== 32'h40) begin
         failures++;
         $display("FAIL starve_id_wr got=%h want 40",
                  bus.hwlp_start_addr_o[1]);
      end
   endtask

   task automatic test_rst_mid_setup();
      bus.id_req_i   = 1'b1;
      bus.id_op_i    = 2'b11;
      bus.id_idx_i   = 1'b1;
      bus.id_start_i = 32'h300;
      bus.id_end_i   = 32'h340;
      bus.id_cnt_i   = 32'd7;
      tick();
      bus.id_req_i = 1'b0;
      tick();
      checks++;
      if (bus.busy_o !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre busy=%b want 1", bus.busy_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.busy_o !== 1'b0 || bus.hwlp_counter_o[1] !== 32'd0 ||
          bus.hwlp_start_addr_o[1] !== 32'd0 ||
          bus.hwlp_end_addr_o[1] !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid busy=%b cnt=%h st=%h en=%h",
                  bus.busy_o, bus.hwlp_counter_o[1],
                  bus.hwlp_start_addr_o[1], bus.hwlp_end_addr_o[1]);
      end
      tick();
      checks++;
      if (bus.busy_o !== 1'b0 || bus.hwlp_counter_o[1] !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid_after busy=%b cnt=%h want 0 0",
                  bus.busy_o, bus.hwlp_counter_o[1]);
      end
   endtask

   task automatic test_addr_check();
      bus.id_req_i   = 1'b1;
      bus.id_op_i    = 2'b11;
      bus.id_idx_i   = 1'b0;
      bus.id_start_i = 32'h200;
      bus.id_end_i   = 32'h1F0;
      bus.id_cnt_i   = 32'd9;
      #1;
`ifdef HWLP_ADDR_CHECK_EN
      checks++;
      if (bus.id_gnt_o !== 1'b1 || bus.id_err_o !== 1'b1) begin
         failures++;
         $display("FAIL chk_err gnt=%b err=%b want 1 1",
                  bus.id_gnt_o, bus.id_err_o);
      end
      tick();
      bus.id_req_i = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.busy_o !== 1'b0 || bus.hwlp_start_addr_o[0] !== 32'd0 ||
          bus.hwlp_end_addr_o[0] !== 32'd0 ||
          bus.hwlp_counter_o[0] !== 32'd0) begin
         failures++;
         $display("FAIL chk_nowr busy=%b st=%h en=%h cnt=%h",
                  bus.busy_o, bus.hwlp_start_addr_o[0],
                  bus.hwlp_end_addr_o[0], bus.hwlp_counter_o[0]);
      end
`else
      checks++;
      if (bus.id_gnt_o !== 1'b1 || bus.id_err_o !== 1'b0) begin
         failures++;
         $display("FAIL nochk_gnt gnt=%b err=%b want 1 0",
                  bus.id_gnt_o, bus.id_err_o);
      end
      tick();
      bus.id_req_i = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.busy_o !== 1'b0 || bus.hwlp_start_addr_o[0] !== 32'h200 ||
          bus.hwlp_end_addr_o[0] !== 32'h1F0 ||
          bus.hwlp_counter_o[0] !== 32'd9) begin
         failures++;
         $display("FAIL nochk_wr busy=%b st=%h en=%h cnt=%h",
                  bus.busy_o, bus.hwlp_start_addr_o[0],
                  bus.hwlp_end_addr_o[0], bus.hwlp_counter_o[0]);
      end
`endif
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_setup();
      test_decrement();
      test_write_vs_dec();
      test_csr();
      test_starve();
      test_rst_mid_setup();
      test_addr_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout bench did not finish");
      $fatal(1);
   end
endmodule
